// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
// Holds the NOP filler, the FSM state enum and the FIFO entry layout.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN,
        DRAIN
    } ifb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(
        input logic [31:0] a
    );
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifb_fifo.sv
// In-order FIFO of fetched {addr, instr} entries for the fetch buffer.
// Ports: clk, reset (async, active-low), clear (sync flush), push/push_data,
// pop, head (oldest entry), count, empty, full.
module ifb_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch front end: prefetches sequential words over req/gnt/rvalid, tags
// them with their address, and presents InstrF for PCF.
// Ports: clk, reset (async, active-low), PCF, StallF, imem_req, imem_addr,
// imem_gnt, imem_rvalid, imem_rdata, InstrF, FetchStall.
// IFB_MISALIGN_CHECK_EN adds output misaligned and blocks fetch while
// PCF[1:0] != 0; without it PCF[1:0] is ignored.
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        StallF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic        FetchStall
`ifdef IFB_MISALIGN_CHECK_EN
    ,
    output logic        misaligned
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    ifb_state_e    state_q;
    ifb_state_e    state_d;
    logic [31:0]   fetch_addr_q;
    logic [31:0]   fetch_addr_d;
    logic [31:0]   resp_addr_q;
    logic [31:0]   resp_addr_d;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] outst_d;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] discard_d;

    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          clear;

    logic [31:0]   pc;
    logic [31:0]   expect_pc;
    logic [SW-1:0] occ;
    logic          hold;
    logic          valid;
    logic          redirect;
    logic          hs;
    logic          rsp;

    assign pc = word_align(PCF);

`ifdef IFB_MISALIGN_CHECK_EN
    assign misaligned = reset && (PCF[1:0] != 2'b00);
    assign hold       = misaligned;
`else
    assign hold = 1'b0;
`endif

    // Address the buffer will deliver next if nothing changes.
    always_comb begin
        expect_pc = fetch_addr_q;
        if (!empty) begin
            expect_pc = head.addr;
        end else if (outst_q > discard_q) begin
            expect_pc = resp_addr_q;
        end
    end

    assign redirect = reset && !hold && (expect_pc != pc);
    assign occ      = SW'(count) + SW'(outst_q);

    assign imem_req  = reset && !hold && !redirect
                     && (state_q == RUN)
                     && (occ < SW'(DEPTH));
    assign imem_addr = fetch_addr_q;

    assign hs  = imem_req && imem_gnt;
    // A response with nothing outstanding is ignored.
    assign rsp = imem_rvalid && (outst_q != '0);

    assign valid = !hold && !empty && (head.addr == pc);
    assign pop   = valid && !StallF;

    assign push_data.addr  = resp_addr_q;
    assign push_data.instr = imem_rdata;

    always_comb begin
        InstrF     = NOP_INSTR;
        FetchStall = 1'b1;
        if (hold) begin
            FetchStall = 1'b0;
        end else if (valid) begin
            InstrF     = head.instr;
            FetchStall = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        resp_addr_d  = resp_addr_q;
        outst_d      = outst_q + CW'(hs) - CW'(rsp);
        discard_d    = discard_q;
        clear        = 1'b0;
        push         = 1'b0;
        if (redirect) begin
            // Everything still in flight belongs to the old stream.
            clear        = 1'b1;
            fetch_addr_d = pc;
            resp_addr_d  = pc;
            discard_d    = outst_d;
            state_d      = (outst_d != '0) ? DRAIN : RUN;
        end else begin
            if (hs) fetch_addr_d = fetch_addr_q + 32'd4;
            if (rsp) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else if (!full || pop) begin
                    push        = 1'b1;
                    resp_addr_d = resp_addr_q + 32'd4;
                end
            end
            unique case (state_q)
                RUN:     state_d = RUN;
                DRAIN:   if (discard_d == '0) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            fetch_addr_q <= RESET_PC;
            resp_addr_q  <= RESET_PC;
            outst_q      <= '0;
            discard_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            resp_addr_q  <= resp_addr_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
        end
    end

    ifb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: random-latency memory model,
// PC driver with jumps, and an address/stream reference model.
module tb_ifetch_buffer;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcf;
    logic        stallf;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic        fstall;
`ifdef IFB_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    always #5 clk = ~clk;

    ifetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (pcf),
        .StallF      (stallf),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (gnt),
        .imem_rvalid (rvalid),
        .imem_rdata  (rdata),
        .InstrF      (instr),
        .FetchStall  (fstall)
`ifdef IFB_MISALIGN_CHECK_EN
        ,
        .misaligned  (misaligned)
`endif
    );

    // Word at each address is unique; address 0 holds 32'h0050_0093.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h0050_0090;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    int          tests = 0;
    int          fails = 0;
    pend_t       pq[$];
    int          cyc = 0;
    int          stale;
    int          stuck;
    int          retired;
    int          lat_extra;
    int          gnt_pct;
    int          rv_pct;
    logic [31:0] next_req;
    bit          adv;
    bit          saw_100_req;
    bit          saw_100_instr;
    logic        o_req;
    logic        o_stall;
    logic [31:0] o_instr;

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        pcf    = 32'h0;
        stallf = 1'b0;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        pq.delete();
        stale    = 0;
        next_req = 32'h0;
        adv      = 1'b0;
        stuck    = 0;
        retired  = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic tick(input bit jump, input logic [31:0] tgt,
                        input bit stall);
        logic [31:0] w;
        pend_t       p;
        @(negedge clk);
        if (adv) pcf = pcf + 32'd4;
        if (jump) begin
            if ((tgt & ~32'h3) == (pcf & ~32'h3))
                tgt = tgt ^ 32'h8000_0000;
            pcf = tgt;
        end
        stallf = stall;
        gnt    = ($urandom_range(99) < gnt_pct);
        rvalid = 1'b0;
        rdata  = 32'hDEAD_BEEF;
        if (pq.size() > 0 && pq[0].ready <= cyc
            && $urandom_range(99) < rv_pct) begin
            rvalid = 1'b1;
            rdata  = memfn(pq[0].addr);
        end
        #1;
        o_req   = imem_req;
        o_stall = fstall;
        o_instr = instr;
        w = pcf & ~32'h3;

        tests++;
        if (fstall === 1'b0) begin
            if (instr !== memfn(w)) begin
                fails++;
                $display("FAIL instr pc=%h got %h want %h",
                         pcf, instr, memfn(w));
            end
        end else if (fstall === 1'b1) begin
            if (instr !== NOP) begin
                fails++;
                $display("FAIL nop pc=%h got %h want %h",
                         pcf, instr, NOP);
            end
        end else begin
            fails++;
            $display("FAIL stall_x got %b want 0/1", fstall);
        end

        if (jump || stale > 0) begin
            tests++;
            if (imem_req !== 1'b0) begin
                fails++;
                $display("FAIL req_drain got %b want 0 stale=%0d",
                         imem_req, stale);
            end
        end

        if (imem_req === 1'b1) begin
            tests++;
            if ((imem_addr - w) > 32'(DEPTH * 4)) begin
                fails++;
                $display("FAIL lead addr=%h pc=%h max %0d",
                         imem_addr, w, DEPTH * 4);
            end
        end

        if (fstall === 1'b1) stuck++;
        else stuck = 0;
        tests++;
        if (stuck > 100) begin
            fails++;
            $display("FAIL liveness pc=%h stalled %0d want <=100",
                     pcf, stuck);
            stuck = 0;
        end

        if (rvalid) begin
            void'(pq.pop_front());
            if (stale > 0) stale--;
        end
        if (jump) begin
            stale    = pq.size();
            next_req = w;
        end
        if (imem_req === 1'b1 && gnt) begin
            tests++;
            if (imem_addr !== next_req) begin
                fails++;
                $display("FAIL req_addr got %h want %h",
                         imem_addr, next_req);
            end
            if (imem_addr == 32'h100) saw_100_req = 1'b1;
            p.addr  = imem_addr;
            p.ready = cyc + 1 + int'($urandom_range(lat_extra));
            pq.push_back(p);
            next_req = next_req + 32'd4;
        end
        if (fstall === 1'b0 && instr === memfn(32'h100))
            saw_100_instr = 1'b1;
        adv = (fstall === 1'b0) && !stall;
        if (adv) retired++;
        cyc++;
    endtask

    task automatic zero_wait();
        gnt_pct   = 100;
        rv_pct    = 100;
        lat_extra = 0;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        pcf    = 32'h0;
        stallf = 1'b0;
        gnt    = 1'b1;
        rvalid = 1'b0;
        rdata  = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rst_req got %b want 0", imem_req);
        end
        tests++;
        if (imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL rst_addr got %h want 0", imem_addr);
        end
        tests++;
        if (instr !== NOP) begin
            fails++;
            $display("FAIL rst_instr got %h want %h", instr, NOP);
        end
        tests++;
        if (fstall !== 1'b1) begin
            fails++;
            $display("FAIL rst_stall got %b want 1", fstall);
        end
    endtask

    task automatic test_first_fetch();
        logic s0;
        logic s1;
        do_reset();
        zero_wait();
        tick(1'b0, 32'h0, 1'b0);
        s0 = o_stall;
        tick(1'b0, 32'h0, 1'b0);
        s1 = o_stall;
        tick(1'b0, 32'h0, 1'b0);
        tests++;
        if (s0 !== 1'b1 || s1 !== 1'b1) begin
            fails++;
            $display("FAIL first_early got %b%b want 11", s0, s1);
        end
        tests++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL first_stall got %b want 0", o_stall);
        end
        tests++;
        if (o_instr !== 32'h0050_0093) begin
            fails++;
            $display("FAIL first_instr got %h want 00500093", o_instr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        zero_wait();
        repeat (60) tick(1'b0, 32'h0, 1'b0);
        tests++;
        if (retired < 36) begin
            fails++;
            $display("FAIL stream retired %0d want >=36", retired);
        end
    endtask

    task automatic test_stall();
        logic [31:0] nxt;
        int          held;
        int          n;
        do_reset();
        zero_wait();
        held = 0;
        n    = 0;
        while (n < 40 && held < 5) begin
            nxt = adv ? pcf + 32'd4 : pcf;
            tick(1'b0, 32'h0, nxt == 32'h8);
            if (pcf == 32'h8 && o_stall === 1'b0) begin
                held++;
                tests++;
                if (o_instr !== memfn(32'h8)) begin
                    fails++;
                    $display("FAIL stall_hold got %h want %h",
                             o_instr, memfn(32'h8));
                end
            end
            n++;
        end
        tests++;
        if (held != 5) begin
            fails++;
            $display("FAIL stall_cnt got %0d want 5", held);
        end
        tests++;
        if (o_req !== 1'b0) begin
            fails++;
            $display("FAIL stall_req got %b want 0", o_req);
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        zero_wait();
        rv_pct = 0;
        repeat (4) tick(1'b0, 32'h0, 1'b0);
        rv_pct = 100;
        tick(1'b1, 32'h100, 1'b0);
        n = 0;
        while (n < 20 && o_stall !== 1'b0) begin
            tick(1'b0, 32'h0, 1'b1);
            n++;
        end
        tests++;
        if (pcf !== 32'h100 || o_instr !== memfn(32'h100)) begin
            fails++;
            $display("FAIL redirect pc=%h got %h want %h",
                     pcf, o_instr, memfn(32'h100));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        zero_wait();
        rv_pct = 0;
        repeat (4) tick(1'b0, 32'h0, 1'b0);
        saw_100_req   = 1'b0;
        saw_100_instr = 1'b0;
        tick(1'b1, 32'h100, 1'b0);
        rv_pct = 100;
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h200, 1'b0);
        n = 0;
        while (n < 60 && pcf != 32'h210) begin
            tick(1'b0, 32'h0, 1'b0);
            n++;
        end
        tests++;
        if (pcf !== 32'h210) begin
            fails++;
            $display("FAIL b2b_reach got %h want 00000210", pcf);
        end
        tests++;
        if (saw_100_req) begin
            fails++;
            $display("FAIL b2b_req got 1 want 0 (0x100 fetched)");
        end
        tests++;
        if (saw_100_instr) begin
            fails++;
            $display("FAIL b2b_instr got 1 want 0 (mem[0x100] shown)");
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        gnt_pct   = 80;
        rv_pct    = 80;
        lat_extra = 2;
        tick(1'b1, 32'hFFFF_FFF8, 1'b0);
        n = 0;
        while (n < 100 && pcf != 32'h8) begin
            tick(1'b0, 32'h0, 1'b0);
            n++;
        end
        tests++;
        if (pcf !== 32'h8) begin
            fails++;
            $display("FAIL wrap_reach got %h want 00000008", pcf);
        end
    endtask

    task automatic test_misalign();
`ifdef IFB_MISALIGN_CHECK_EN
        do_reset();
        @(negedge clk);
        pcf = 32'h102;
        gnt = 1'b1;
        #1;
        tests++;
        if (misaligned !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL mis_flag got %b/%b want 1/0",
                     misaligned, imem_req);
        end
        tests++;
        if (instr !== NOP || fstall !== 1'b0) begin
            fails++;
            $display("FAIL mis_out got %h/%b want %h/0",
                     instr, fstall, NOP);
        end
        @(negedge clk);
        pcf = 32'h0;
        gnt = 1'b0;
`else
        int n;
        do_reset();
        zero_wait();
        tick(1'b1, 32'h102, 1'b1);
        n = 0;
        while (n < 20 && o_stall !== 1'b0) begin
            tick(1'b0, 32'h0, 1'b1);
            n++;
        end
        tests++;
        if (o_stall !== 1'b0 || o_instr !== memfn(32'h100)) begin
            fails++;
            $display("FAIL misalign got %h/%b want %h/0",
                     o_instr, o_stall, memfn(32'h100));
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        bit          j;
        do_reset();
        gnt_pct   = 70;
        rv_pct    = 70;
        lat_extra = 3;
        for (int i = 0; i < 1500; i++) begin
            j = ($urandom_range(99) < 4);
            if ($urandom_range(1) == 0)
                tgt = $urandom & ~32'h3;
            else
                tgt = pcf + 32'(4 * $urandom_range(1, 6));
            tick(j, tgt, $urandom_range(99) < 20);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
